// File: rtl/led_fade_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// led_fade_ctrl_pkg : register map, channel constants and ramp helper
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package led_fade_ctrl_pkg;

  localparam int NCH = 3;
  localparam int W   = 8;

  localparam logic [2:0] A_TGT0 = 3'd0;
  localparam logic [2:0] A_TGT1 = 3'd1;
  localparam logic [2:0] A_TGT2 = 3'd2;
  localparam logic [2:0] A_RATE = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4;
  localparam logic [2:0] A_CUR0 = 3'd5;
  localparam logic [2:0] A_CUR1 = 3'd6;
  localparam logic [2:0] A_CUR2 = 3'd7;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } sched_state_e;

  // One ramp step toward tgt; the last step lands exactly on tgt.
  function automatic logic [W-1:0] ramp_step(input logic [W-1:0] cur,
                                             input logic [W-1:0] tgt,
                                             input logic [W:0]   step);
    logic [W:0] diff;
    logic [W:0] sum;
    ramp_step = cur;
    diff      = '0;
    sum       = '0;
    if (tgt > cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
      sum  = {1'b0, cur} + step;
      ramp_step = (diff <= step) ? tgt : sum[W-1:0];
    end else if (tgt < cur) begin
      diff = {1'b0, cur} - {1'b0, tgt};
      sum  = {1'b0, cur} - step;
      ramp_step = (diff <= step) ? tgt : sum[W-1:0];
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_rr_arb.sv
// ----------------------------------------------------------------------------
// led_rr_arb : 3-request round-robin arbiter, one-hot grant + pointer update
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module led_rr_arb
  import led_fade_ctrl_pkg::*;
(
  input  logic [NCH-1:0] req_i,
  input  logic [1:0]     ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [1:0]     gnt_idx_o,
  output logic [1:0]     ptr_nxt_o
);

  logic       found;
  logic [1:0] cand;

  // ptr_i names the highest-priority channel for this cycle.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = ptr_i;
    ptr_nxt_o = ptr_i;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = 2'((int'(ptr_i) + k) % NCH);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
        ptr_nxt_o   = 2'((int'(cand) + 1) % NCH);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_fade_ctrl.sv
// ----------------------------------------------------------------------------
// led_fade_ctrl : host register file, prescaled brightness ramps, LED write scheduler
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module led_fade_ctrl
  import led_fade_ctrl_pkg::*;
#(
  parameter int STEP      = 1,
  parameter int PRE_SHIFT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rd_en,
  input  logic         wr_en,
  input  logic [2:0]   addr,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         rd_valid,
  output logic         led_wr_en,
  output logic [1:0]   led_addr,
  output logic [W-1:0] led_wr_data,
  output logic         fade_done
);

  localparam int         PW     = W + 1 + PRE_SHIFT;
  localparam logic [W:0] STEP_V = (W+1)'(STEP);

  logic [NCH-1:0][W-1:0] cur_q, cur_d, tgt_q, tgt_d, step_lvl;
  logic [W-1:0]          rate_q, rate_d;
  logic [NCH-1:0]        fade_en_q, fade_en_d;
  logic [PW-1:0]         presc_q, presc_d, period_m1;
  logic [NCH-1:0]        pending_q, pending_d, set_pend, clr_pend;
  logic [1:0]            ptr_q, ptr_d;
  sched_state_e          state_q, state_d;
  logic [W-1:0]          rd_data_q, rd_data_d, rd_mux;
  logic                  rd_valid_q, rd_valid_d;
  logic                  led_wr_en_q, led_wr_en_d;
  logic [1:0]            led_addr_q, led_addr_d;
  logic [W-1:0]          led_wr_data_q, led_wr_data_d;
  logic                  fade_done_q, fade_done_d;
  logic                  tick;
  logic [NCH-1:0]        gnt;
  logic [1:0]            gnt_idx, ptr_nxt;

  assign period_m1 = ((PW'(rate_q) + PW'(1)) << PRE_SHIFT) - PW'(1);
  assign tick      = (presc_q == period_m1);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign step_lvl[g] = ramp_step(cur_q[g], tgt_q[g], STEP_V);
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_TGT0:  rd_mux = tgt_q[0];
      A_TGT1:  rd_mux = tgt_q[1];
      A_TGT2:  rd_mux = tgt_q[2];
      A_RATE:  rd_mux = rate_q;
      A_CTRL:  rd_mux = {{(W-NCH){1'b0}}, fade_en_q};
      A_CUR0:  rd_mux = cur_q[0];
      A_CUR1:  rd_mux = cur_q[1];
      A_CUR2:  rd_mux = cur_q[2];
      default: rd_mux = '0;
    endcase
  end

  // Register file and ramp datapath; tick always sees pre-write tgt/fade_en.
  always_comb begin
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    rate_d      = rate_q;
    fade_en_d   = fade_en_q;
    presc_d     = tick ? '0 : presc_q + PW'(1);
    set_pend    = '0;
    fade_done_d = 1'b0;
    rd_valid_d  = rd_en;
    rd_data_d   = rd_en ? rd_mux : rd_data_q;

    for (int i = 0; i < NCH; i++) begin
      if (tick && fade_en_q[i] && (cur_q[i] != tgt_q[i])) begin
        cur_d[i]    = step_lvl[i];
        set_pend[i] = 1'b1;
        if (step_lvl[i] == tgt_q[i]) fade_done_d = 1'b1;
      end
      if (wr_en && (addr == A_TGT0 + 3'(i))) begin
        tgt_d[i] = wr_data;
        if (!fade_en_q[i]) begin
          cur_d[i]    = wr_data;
          set_pend[i] = 1'b1;
        end
      end
    end

    if (wr_en && (addr == A_RATE)) begin
      rate_d  = wr_data;
      presc_d = '0;
    end
    if (wr_en && (addr == A_CTRL)) fade_en_d = wr_data[NCH-1:0];
  end

  led_rr_arb u_arb (
    .req_i     (pending_q),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .ptr_nxt_o (ptr_nxt)
  );

  always_comb begin
    led_wr_en_d   = 1'b0;
    led_addr_d    = led_addr_q;
    led_wr_data_d = led_wr_data_q;
    ptr_d         = ptr_q;
    clr_pend      = '0;
    case (state_q)
      S_ISSUE: begin
        led_wr_en_d = 1'b1;
        led_addr_d  = gnt_idx;
        ptr_d       = ptr_nxt;
        clr_pend    = gnt;
        for (int i = 0; i < NCH; i++) begin
          if (gnt[i]) led_wr_data_d = cur_q[i];
        end
      end
      default: ;
    endcase
    // A fresh request in the granting cycle survives the clear.
    pending_d = (pending_q & ~clr_pend) | set_pend;
    state_d   = (pending_d != '0) ? S_ISSUE : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q         <= '0;
      tgt_q         <= '0;
      rate_q        <= '0;
      fade_en_q     <= '0;
      presc_q       <= '0;
      pending_q     <= '1;
      ptr_q         <= '0;
      state_q       <= S_ISSUE;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      led_wr_en_q   <= 1'b0;
      led_addr_q    <= '0;
      led_wr_data_q <= '0;
      fade_done_q   <= 1'b0;
    end else begin
      cur_q         <= cur_d;
      tgt_q         <= tgt_d;
      rate_q        <= rate_d;
      fade_en_q     <= fade_en_d;
      presc_q       <= presc_d;
      pending_q     <= pending_d;
      ptr_q         <= ptr_d;
      state_q       <= state_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      led_wr_en_q   <= led_wr_en_d;
      led_addr_q    <= led_addr_d;
      led_wr_data_q <= led_wr_data_d;
      fade_done_q   <= fade_done_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign led_wr_en   = led_wr_en_q;
  assign led_addr    = led_addr_q;
  assign led_wr_data = led_wr_data_q;
  assign fade_done   = fade_done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_fade_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_fade_ctrl : directed self-checking bench for led_fade_ctrl (STEP=16, PRE_SHIFT=0)
// Rev 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_led_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       led_wr_en;
  logic [1:0] led_addr;
  logic [7:0] led_wr_data;
  logic       fade_done;

  int n_vec = 0;
  int n_bad = 0;

  led_fade_ctrl #(.STEP(16), .PRE_SHIFT(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .rd_en       (rd_en),
    .wr_en       (wr_en),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .led_wr_en   (led_wr_en),
    .led_addr    (led_addr),
    .led_wr_data (led_wr_data),
    .fade_done   (fade_done)
  );

  always #5 clk = ~clk;

  // LED write log and fade_done history, sampled just after each rising edge.
  logic [1:0] q_addr[$];
  logic [7:0] q_data[$];
  int         q_cyc[$];
  int         cyc = 0;
  int         fd_cnt = 0;
  int         fd_cyc = -1;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (led_wr_en === 1'b1) begin
      q_addr.push_back(led_addr);
      q_data.push_back(led_wr_data);
      q_cyc.push_back(cyc);
    end
    if (fade_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_cyc = cyc;
    end
  end

  task automatic clr_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    fd_cnt = 0;
    fd_cyc = -1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the write is sampled on the next rising edge.
  task automatic drive_wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  r_cyc;
    int  w_cyc;
    int  lat;
    bit  found;
    logic [7:0] lvl;

    // Reset state and post-reset resync of all three channels.
    repeat (3) @(negedge clk);
    chk("rst_led_wr_en", 32'(led_wr_en), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_fade_done", 32'(fade_done), 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("resync%0d_en", k), 32'(led_wr_en), 1);
      chk($sformatf("resync%0d_addr", k), 32'(led_addr), 32'(k));
      chk($sformatf("resync%0d_data", k), 32'(led_wr_data), 0);
    end
    @(negedge clk);
    chk("resync_idle", 32'(led_wr_en), 0);

    // Jump write with fade disabled.
    clr_log();
    drive_wr(3'd1, 8'h80);
    w_cyc = cyc;
    repeat (4) @(negedge clk);
    chk("jump_nwr", 32'(q_data.size()), 1);
    if (q_data.size() >= 1) begin
      chk("jump_addr", 32'(q_addr[0]), 1);
      chk("jump_data", 32'(q_data[0]), 32'h80);
      lat = q_cyc[0] - w_cyc;
      chk("jump_latency_ok", 32'(lat >= 1 && lat <= 3), 1);
    end
    rd_chk("jump_cur1", 3'd6, 8'h80);
    rd_chk("jump_tgt1", 3'd1, 8'h80);

    // Single-channel ramp up 0 -> 0x25 in steps of 16, tick every 4 cycles.
    clr_log();
    drive_wr(3'd3, 8'd3);
    r_cyc = cyc;
    drive_wr(3'd4, 8'h01);
    drive_wr(3'd0, 8'h25);
    repeat (20) @(negedge clk);
    chk("ramp_nwr", 32'(q_data.size()), 3);
    if (q_data.size() >= 3) begin
      chk("ramp_l0", 32'(q_data[0]), 32'h10);
      chk("ramp_l1", 32'(q_data[1]), 32'h20);
      chk("ramp_l2", 32'(q_data[2]), 32'h25);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("ramp_a%0d", k), 32'(q_addr[k]), 0);
        chk($sformatf("ramp_t%0d", k), 32'(q_cyc[k] - r_cyc), 32'(5 + 4 * k));
      end
    end
    chk("ramp_fd_cnt", 32'(fd_cnt), 1);
    chk("ramp_fd_when", 32'(fd_cyc - r_cyc), 32'd12);
    rd_chk("ramp_cur0", 3'd5, 8'h25);

    // Three concurrent ramps 0xFF -> 0x00.
    drive_wr(3'd4, 8'h00);
    drive_wr(3'd0, 8'hFF);
    drive_wr(3'd1, 8'hFF);
    drive_wr(3'd2, 8'hFF);
    repeat (6) @(negedge clk);
    clr_log();
    drive_wr(3'd4, 8'h07);
    drive_wr(3'd3, 8'd3);
    drive_wr(3'd0, 8'h00);
    drive_wr(3'd1, 8'h00);
    drive_wr(3'd2, 8'h00);
    repeat (75) @(negedge clk);
    chk("multi_nwr", 32'(q_data.size()), 48);
    if (q_data.size() >= 48) begin
      for (int k = 0; k < 16; k++) begin
        lvl = (k < 15) ? 8'(255 - 16 * (k + 1)) : 8'h00;
        for (int j = 0; j < 3; j++) begin
          chk($sformatf("multi_t%0d_a%0d", k, j), 32'(q_addr[3*k+j]), 32'(j));
          chk($sformatf("multi_t%0d_d%0d", k, j), 32'(q_data[3*k+j]), 32'(lvl));
        end
      end
    end
    chk("multi_fd_cnt", 32'(fd_cnt), 1);

    // Disable mid-ramp at 0x40: level freezes.
    drive_wr(3'd4, 8'h01);
    clr_log();
    drive_wr(3'd0, 8'h80);
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (q_data.size() > 0 && q_addr[$] == 2'd0 && q_data[$] == 8'h40) found = 1'b1;
    end
    chk("freeze_reached_40", 32'(found), 1);
    drive_wr(3'd4, 8'h00);
    clr_log();
    repeat (45) @(negedge clk);
    chk("freeze_nwr", 32'(q_data.size()), 0);
    rd_chk("freeze_cur0", 3'd5, 8'h40);
    rd_chk("freeze_ctrl", 3'd4, 8'h00);
    rd_chk("freeze_tgt0", 3'd0, 8'h80);

    // Tick and tgt write on the same edge, then reset mid-issue.
    drive_wr(3'd3, 8'd3);
    drive_wr(3'd4, 8'h01);
    repeat (2) @(negedge clk);
    drive_wr(3'd0, 8'h00);
    rd_chk("same_cyc_cur0", 3'd5, 8'h50);
    drive_wr(3'd1, 8'h33);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_led_wr_en", 32'(led_wr_en), 0);
    chk("midrst_rd_valid", 32'(rd_valid), 0);
    chk("midrst_rd_data", 32'(rd_data), 0);
    chk("midrst_fade_done", 32'(fade_done), 0);
    rst = 1'b0;
    clr_log();
    repeat (5) @(negedge clk);
    chk("midrst_nwr", 32'(q_data.size()), 3);
    if (q_data.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("midrst_a%0d", k), 32'(q_addr[k]), 32'(k));
        chk($sformatf("midrst_d%0d", k), 32'(q_data[k]), 0);
      end
      chk("midrst_back2back", 32'(q_cyc[2] - q_cyc[0]), 2);
    end
    rd_chk("midrst_cur0", 3'd5, 8'h00);
    rd_chk("midrst_cur1", 3'd6, 8'h00);
    rd_chk("midrst_tgt1", 3'd1, 8'h00);
    rd_chk("midrst_rate", 3'd3, 8'h00);
    rd_chk("midrst_ctrl", 3'd4, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
